// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/add/sub/compare, iterative unsigned
// multiply (shift-add, LSB first) and divide (restoring, MSB first) over
// WIDTH cycles, with a start/busy/done handshake. Outputs are registered
// and change only in the done cycle.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALU_opc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Rem,
    output logic             Zero,
    output logic             Ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;      // MUL: shifted multiplicand; DIV: dividend/quotient
    logic [WIDTH-1:0] opb_q, opb_d;      // MUL: shifted multiplier;   DIV: divisor
    logic [WIDTH-1:0] acc_q, acc_d;      // MUL: product accumulator;  DIV: partial remainder
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    // Single-cycle datapath, evaluated on the live operands
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf, slt, sltu;

    assign sum     = A + B;
    assign diff    = A - B;
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    assign slt     = $signed(A) < $signed(B);
    assign sltu    = A < B;

    // Iterative datapath, evaluated on the latched operands
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             last;

    assign mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
    assign trial    = {acc_q, opa_q[WIDTH-1]};
    assign qbit     = trial >= {1'b0, opb_q};
    // trial < 2*divisor, so the difference always fits in WIDTH bits
    assign rem_next = qbit ? (trial[WIDTH-1:0] - opb_q) : trial[WIDTH-1:0];
    assign quo_next = {opa_q[WIDTH-2:0], qbit};
    assign last     = (cnt_q == CNT_ONE);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Next-state, iteration steps and output register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ALU_opc[2:1] == 2'b11) begin
                        opa_d   = A;
                        opb_d   = B;
                        acc_d   = '0;
                        cnt_d   = CNT_INIT;
                        state_d = ALU_opc[0] ? S_DIV : S_MUL;
                    end else begin
                        rem_d  = '0;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                        unique case (ALU_opc)
                            3'b000:  result_d = A & B;
                            3'b001:  result_d = A | B;
                            3'b010: begin
                                result_d = sum;
                                ovf_d    = add_ovf;
                            end
                            3'b011: begin
                                result_d = diff;
                                ovf_d    = sub_ovf;
                            end
                            3'b100:  result_d = WIDTH'(slt);
                            default: result_d = WIDTH'(sltu);
                        endcase
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                opa_d = {opa_q[WIDTH-2:0], 1'b0};
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_ONE;
                if (last) begin
                    result_d = mul_acc;
                    rem_d    = '0;
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = rem_next;
                opa_d = quo_next;
                cnt_d = cnt_q - CNT_ONE;
                if (last) begin
                    result_d = quo_next;
                    rem_d    = rem_next;
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign Result = result_q;
    assign Rem    = rem_q;
    assign Ovf    = ovf_q;
    assign Zero   = (result_q == '0);

endmodule
